// File: rtl/taxi_eth_tx_arb_pkg.sv
// Shared types and constants for the packet-granular MAC TX arbiter.
package taxi_eth_tx_arb_pkg;

    // Width of the MAC TX completion timestamp
    localparam int TS_W = 96;

    // Arbiter FSM: waiting for a request, or forwarding one locked packet
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PASS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/taxi_arb_rr_sel.sv
// Rotating-priority selector: finds the first requesting port strictly
// after last_grant, wrapping around. last_grant itself has lowest priority.
module taxi_arb_rr_sel #(
    parameter int PORTS = 4,
    parameter int IDX_W = 2
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Walk candidates last_grant+1, +2, ... +PORTS (mod PORTS); first hit wins
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = 1; k <= PORTS; k++) begin
            for (int i = 0; i < PORTS; i++) begin
                if (!found && req[i] && (i == ((int'(last_grant) + k) % PORTS))) begin
                    found = 1'b1;
                    index = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/taxi_eth_mac_tx_arb.sv
// Packet-granular round-robin arbiter sharing one 8-bit MAC TX stream among
// PORTS requesters. Each forwarded packet is tagged with its source index
// (m_tid) and MAC TX completions are routed back to the source by that tag.
//
// Optional feature macro: TAXI_ETH_TX_ARB_CPL_EN
//   defined     -> m_tid carries the grant, completion demux is live
//   not defined -> m_tid = 0, s_cpl_ready = 1, m_cpl_valid = 0; the ports
//                  stay so the footprint does not change between builds
module taxi_eth_mac_tx_arb
    import taxi_eth_tx_arb_pkg::*;
#(
    parameter int PORTS  = 4,
    parameter int ID_W   = $clog2(PORTS),
    parameter int USER_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [PORTS-1:0]        cfg_port_en,

    input  logic [PORTS*8-1:0]      s_tdata,
    input  logic [PORTS-1:0]        s_tvalid,
    output logic [PORTS-1:0]        s_tready,
    input  logic [PORTS-1:0]        s_tlast,
    input  logic [PORTS*USER_W-1:0] s_tuser,

    output logic [7:0]              m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [USER_W-1:0]       m_tuser,
    output logic [ID_W-1:0]         m_tid,

    input  logic                    s_cpl_valid,
    output logic                    s_cpl_ready,
    input  logic [ID_W-1:0]         s_cpl_tid,
    input  logic [TS_W-1:0]         s_cpl_ts,

    output logic [PORTS-1:0]        m_cpl_valid,
    input  logic [PORTS-1:0]        m_cpl_ready,
    output logic [TS_W-1:0]         m_cpl_ts,

    output logic                    busy,
    output logic [ID_W-1:0]         grant_id
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;

    logic [PORTS-1:0] req;
    logic             sel_found;
    logic [ID_W-1:0]  sel_index;

    // Disabled ports never compete; a grant already held is unaffected
    assign req = s_tvalid & cfg_port_en;

    taxi_arb_rr_sel #(
        .PORTS (PORTS),
        .IDX_W (ID_W)
    ) u_rr_sel (
        .req        (req),
        .last_grant (last_grant_q),
        .found      (sel_found),
        .index      (sel_index)
    );

    // Forward path: pure mux of the granted port, only while in PASS
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        m_tuser  = '0;
        s_tready = '0;
        if (state_q == ARB_PASS) begin
            for (int i = 0; i < PORTS; i++) begin
                if (grant_q == ID_W'(i)) begin
                    m_tvalid    = s_tvalid[i];
                    m_tdata     = s_tdata[i*8 +: 8];
                    m_tlast     = s_tlast[i];
                    m_tuser     = s_tuser[i*USER_W +: USER_W];
                    s_tready[i] = m_tready;
                end
            end
        end
    end

    // Next-state: grant in IDLE, release after the tlast beat
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_found) begin
                    state_d      = ARB_PASS;
                    grant_d      = sel_index;
                    last_grant_d = sel_index;
                end
            end
            ARB_PASS: begin
                if (m_tvalid && m_tready && m_tlast) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; last_grant resets to PORTS-1 so port 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy     = (state_q == ARB_PASS);
    assign grant_id = grant_q;
    assign m_cpl_ts = s_cpl_ts;

`ifdef TAXI_ETH_TX_ARB_CPL_EN
    assign m_tid = grant_q;

    // Completion demux: tags with no matching port are accepted and dropped
    always_comb begin
        m_cpl_valid = '0;
        s_cpl_ready = 1'b1;
        for (int i = 0; i < PORTS; i++) begin
            if (s_cpl_tid == ID_W'(i)) begin
                m_cpl_valid[i] = s_cpl_valid;
                s_cpl_ready    = m_cpl_ready[i];
            end
        end
    end
`else
    logic unused_cpl;

    assign m_tid       = '0;
    assign s_cpl_ready = 1'b1;
    assign m_cpl_valid = '0;
    assign unused_cpl  = ^{s_cpl_valid, s_cpl_tid, m_cpl_ready};
`endif

endmodule

// File: tb/tb_taxi_eth_mac_tx_arb.sv
// Directed bench for taxi_eth_mac_tx_arb (PORTS=4, ID_W=3 so tag 7 exists).
module tb_taxi_eth_mac_tx_arb;

    localparam int PORTS  = 4;
    localparam int ID_W   = 3;
    localparam int USER_W = 1;
    localparam int TS_W   = 96;
`ifdef TAXI_ETH_TX_ARB_CPL_EN
    localparam bit CPL_EN = 1'b1;
`else
    localparam bit CPL_EN = 1'b0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic [PORTS-1:0]        cfg_port_en;
    logic [PORTS*8-1:0]      s_tdata;
    logic [PORTS-1:0]        s_tvalid;
    logic [PORTS-1:0]        s_tready;
    logic [PORTS-1:0]        s_tlast;
    logic [PORTS*USER_W-1:0] s_tuser;
    logic [7:0]              m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;
    logic [USER_W-1:0]       m_tuser;
    logic [ID_W-1:0]         m_tid;
    logic                    s_cpl_valid;
    logic                    s_cpl_ready;
    logic [ID_W-1:0]         s_cpl_tid;
    logic [TS_W-1:0]         s_cpl_ts;
    logic [PORTS-1:0]        m_cpl_valid;
    logic [PORTS-1:0]        m_cpl_ready;
    logic [TS_W-1:0]         m_cpl_ts;
    logic                    busy;
    logic [ID_W-1:0]         grant_id;

    taxi_eth_mac_tx_arb #(
        .PORTS  (PORTS),
        .ID_W   (ID_W),
        .USER_W (USER_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_port_en (cfg_port_en),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .m_tid       (m_tid),
        .s_cpl_valid (s_cpl_valid),
        .s_cpl_ready (s_cpl_ready),
        .s_cpl_tid   (s_cpl_tid),
        .s_cpl_ts    (s_cpl_ts),
        .m_cpl_valid (m_cpl_valid),
        .m_cpl_ready (m_cpl_ready),
        .m_cpl_ts    (m_cpl_ts),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Source model: each port replays pkt_data[i][0..pkt_len-1]
    logic [7:0] pkt_data [PORTS][8];
    int         pkt_len  [PORTS];
    int         beat_idx [PORTS];
    bit         src_on   [PORTS];
    bit         rep      [PORTS];

    // Values sampled at the negedge of the last step
    logic            obs_busy, obs_mv, obs_ml, obs_fire, obs_mr;
    logic [7:0]      obs_md;
    logic [ID_W-1:0] obs_grant, obs_tid;
    logic [3:0]      obs_str;

    // Beat log (every m_tvalid & m_tready transfer) and completed-packet log
    int         log_port [$];
    logic [7:0] log_data [$];
    logic       log_last [$];
    logic       log_user [$];
    int         pkt_ports [$];

    task automatic drive_srcs();
        for (int i = 0; i < PORTS; i++) begin
            s_tvalid[i]       = src_on[i];
            s_tdata[i*8 +: 8] = pkt_data[i][beat_idx[i]];
            s_tlast[i]        = (beat_idx[i] == pkt_len[i] - 1);
            s_tuser[i]        = 1'(beat_idx[i] % 2);
        end
    endtask

    task automatic log_clear();
        log_port.delete();
        log_data.delete();
        log_last.delete();
        log_user.delete();
        pkt_ports.delete();
    endtask

    // One clock: observe at negedge, then advance sources just after posedge
    task automatic step();
        logic [PORTS-1:0] s_fire;
        @(negedge clk);
        obs_busy  = busy;
        obs_grant = grant_id;
        obs_mv    = m_tvalid;
        obs_md    = m_tdata;
        obs_ml    = m_tlast;
        obs_tid   = m_tid;
        obs_str   = s_tready;
        obs_mr    = m_tready;
        obs_fire  = m_tvalid && m_tready;
        s_fire    = s_tvalid & s_tready;
        if (obs_fire) begin
            log_port.push_back(int'(grant_id));
            log_data.push_back(m_tdata);
            log_last.push_back(m_tlast);
            log_user.push_back(m_tuser[0]);
            if (m_tlast) pkt_ports.push_back(int'(grant_id));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < PORTS; i++) begin
            if (s_fire[i]) begin
                if (beat_idx[i] == pkt_len[i] - 1) begin
                    beat_idx[i] = 0;
                    if (!rep[i]) src_on[i] = 1'b0;
                end else begin
                    beat_idx[i] = beat_idx[i] + 1;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic srcs_off();
        for (int i = 0; i < PORTS; i++) begin
            src_on[i]   = 1'b0;
            beat_idx[i] = 0;
            rep[i]      = 1'b0;
        end
        drive_srcs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        cfg_port_en = 4'hF;
        m_tready    = 1'b1;
        s_cpl_valid = 1'b0;
        s_cpl_tid   = '0;
        s_cpl_ts    = '0;
        m_cpl_ready = '0;
        for (int i = 0; i < PORTS; i++) pkt_len[i] = 1;
        srcs_off();
        #3;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++;
        if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%0b exp=0", m_tvalid); end
        checks++;
        if (s_tready !== 4'b0000) begin failures++; $display("FAIL reset_s_tready got=%b exp=0000", s_tready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [7:0]      exp_d [3];
        logic [ID_W-1:0] exp_tid;
        exp_d   = '{8'h11, 8'h22, 8'h33};
        exp_tid = CPL_EN ? 3'd2 : 3'd0;
        log_clear();
        pkt_len[2]     = 3;
        pkt_data[2][0] = 8'h11;
        pkt_data[2][1] = 8'h22;
        pkt_data[2][2] = 8'h33;
        src_on[2]      = 1'b1;
        drive_srcs();
        step();
        checks++;
        if (obs_busy !== 1'b0 || obs_mv !== 1'b0 || obs_str !== 4'b0000)
        begin failures++; $display("FAIL single_idle got busy=%0b mv=%0b str=%b exp 0 0 0000", obs_busy, obs_mv, obs_str); end
        step();
        checks++;
        if (obs_busy !== 1'b1 || obs_grant !== 3'd2)
        begin failures++; $display("FAIL single_grant got busy=%0b grant=%0d exp 1 2", obs_busy, obs_grant); end
        checks++;
        if (obs_tid !== exp_tid) begin failures++; $display("FAIL single_tid got=%0d exp=%0d", obs_tid, exp_tid); end
        checks++;
        if (obs_str !== 4'b0100) begin failures++; $display("FAIL single_s_tready got=%b exp=0100", obs_str); end
        step();
        step();
        step();
        checks++;
        if (obs_busy !== 1'b0 || obs_mv !== 1'b0)
        begin failures++; $display("FAIL single_release got busy=%0b mv=%0b exp 0 0", obs_busy, obs_mv); end
        checks++;
        if (log_data.size() != 3) begin
            failures++; $display("FAIL single_beats got=%0d exp=3", log_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (log_port[k] != 2 || log_data[k] !== exp_d[k] || log_last[k] !== (k == 2) || log_user[k] !== 1'(k % 2))
                begin failures++; $display("FAIL single_beat%0d got port=%0d d=%h l=%0b u=%0b exp port=2 d=%h l=%0b u=%0b",
                    k, log_port[k], log_data[k], log_last[k], log_user[k], exp_d[k], (k == 2), k % 2); end
            end
        end
        srcs_off();
    endtask

    task automatic test_cpl();
        logic [TS_W-1:0] ts_a, ts_b;
        ts_a = 96'h0123_4567_89ab_cdef_fedc_ba98;
        ts_b = 96'hdead_beef_0000_1111_2222_3333;
        s_cpl_ts    = ts_a;
        s_cpl_valid = 1'b1;
        s_cpl_tid   = 3'd3;
        m_cpl_ready = 4'b0111;
        #1;
        checks++;
        if (m_cpl_valid !== (CPL_EN ? 4'b1000 : 4'b0000))
        begin failures++; $display("FAIL cpl_tag3_valid got=%b exp=%b", m_cpl_valid, CPL_EN ? 4'b1000 : 4'b0000); end
        checks++;
        if (s_cpl_ready !== !CPL_EN) begin failures++; $display("FAIL cpl_tag3_stall got=%0b exp=%0b", s_cpl_ready, !CPL_EN); end
        checks++;
        if (m_cpl_ts !== ts_a) begin failures++; $display("FAIL cpl_ts_a got=%h exp=%h", m_cpl_ts, ts_a); end
        m_cpl_ready = 4'b1111;
        #1;
        checks++;
        if (s_cpl_ready !== 1'b1) begin failures++; $display("FAIL cpl_tag3_go got=%0b exp=1", s_cpl_ready); end
        s_cpl_tid   = 3'd7;
        m_cpl_ready = 4'b0000;
        s_cpl_ts    = ts_b;
        #1;
        checks++;
        if (m_cpl_valid !== 4'b0000 || s_cpl_ready !== 1'b1)
        begin failures++; $display("FAIL cpl_tag7_drop got valid=%b ready=%0b exp 0000 1", m_cpl_valid, s_cpl_ready); end
        checks++;
        if (m_cpl_ts !== ts_b) begin failures++; $display("FAIL cpl_ts_b got=%h exp=%h", m_cpl_ts, ts_b); end
        s_cpl_tid   = 3'd1;
        m_cpl_ready = 4'b0010;
        #1;
        checks++;
        if (m_cpl_valid !== (CPL_EN ? 4'b0010 : 4'b0000) || s_cpl_ready !== 1'b1)
        begin failures++; $display("FAIL cpl_tag1 got valid=%b ready=%0b", m_cpl_valid, s_cpl_ready); end
        s_cpl_valid = 1'b0;
        #1;
        checks++;
        if (m_cpl_valid !== 4'b0000) begin failures++; $display("FAIL cpl_novalid got=%b exp=0000", m_cpl_valid); end
        m_cpl_ready = '0;
        s_cpl_tid   = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr();
        int exp_order [5];
        int n, idle;
        bit seen;
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        log_clear();
        for (int i = 0; i < PORTS; i++) begin
            pkt_len[i]     = 2;
            pkt_data[i][0] = 8'(i * 16);
            pkt_data[i][1] = 8'(i * 16 + 1);
            rep[i]         = 1'b1;
            src_on[i]      = 1'b1;
            beat_idx[i]    = 0;
        end
        drive_srcs();
        n = 0; idle = 0; seen = 1'b0;
        while (pkt_ports.size() < 5 && n < 60) begin
            step();
            n++;
            if (obs_busy) seen = 1'b1;
            else if (seen) idle++;
        end
        srcs_off();
        checks++;
        if (pkt_ports.size() != 5) begin
            failures++; $display("FAIL rr_timeout got=%0d packets exp=5", pkt_ports.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (pkt_ports[k] != exp_order[k])
                begin failures++; $display("FAIL rr_order%0d got=%0d exp=%0d", k, pkt_ports[k], exp_order[k]); end
            end
            checks++;
            if (idle != 4) begin failures++; $display("FAIL rr_idle_gaps got=%0d exp=4", idle); end
            checks++;
            if (log_data.size() != 10) begin failures++; $display("FAIL rr_beats got=%0d exp=10", log_data.size()); end
            else for (int k = 0; k < 10; k++) begin
                checks++;
                if (log_data[k] !== 8'(exp_order[k/2] * 16 + k % 2) || log_last[k] !== 1'(k % 2))
                begin failures++; $display("FAIL rr_beat%0d got d=%h l=%0b exp d=%h l=%0b",
                    k, log_data[k], log_last[k], 8'(exp_order[k/2] * 16 + k % 2), k % 2); end
            end
        end
    endtask

    task automatic test_backpressure();
        int         exp_port [6];
        logic [7:0] exp_d [6];
        int n, bad;
        exp_port = '{1, 1, 1, 1, 3, 3};
        exp_d    = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        log_clear();
        pkt_len[1] = 4;
        for (int b = 0; b < 4; b++) pkt_data[1][b] = exp_d[b];
        pkt_len[3] = 2;
        pkt_data[3][0] = 8'hB1;
        pkt_data[3][1] = 8'hB2;
        src_on[1] = 1'b1;
        src_on[3] = 1'b1;
        m_tready  = 1'b1;
        drive_srcs();
        n = 0; bad = 0;
        while ((src_on[1] || src_on[3]) && n < 40) begin
            step();
            n++;
            if (obs_busy) begin
                if ((obs_str & ~(4'b0001 << obs_grant)) !== 4'b0000) bad++;
                if (obs_str[obs_grant] !== obs_mr) bad++;
            end
            m_tready = ~m_tready;
        end
        m_tready = 1'b1;
        checks++;
        if (n >= 40) begin failures++; $display("FAIL bp_timeout got=%0d cycles exp<40", n); end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_s_tready got=%0d bad cycles exp=0", bad); end
        checks++;
        if (log_data.size() != 6) begin
            failures++; $display("FAIL bp_beats got=%0d exp=6", log_data.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (log_port[k] != exp_port[k] || log_data[k] !== exp_d[k] || log_last[k] !== (k == 3 || k == 5))
                begin failures++; $display("FAIL bp_beat%0d got port=%0d d=%h l=%0b exp port=%0d d=%h",
                    k, log_port[k], log_data[k], log_last[k], exp_port[k], exp_d[k]); end
            end
        end
        srcs_off();
    endtask

    task automatic test_cfg_en();
        int exp_order [7];
        int n;
        bit cleared;
        exp_order = '{0, 2, 3, 0, 2, 3, 2};
        log_clear();
        cfg_port_en = 4'b1101;
        for (int i = 0; i < PORTS; i++) begin
            pkt_len[i]     = 2;
            pkt_data[i][0] = 8'(i * 16);
            pkt_data[i][1] = 8'(i * 16 + 1);
            rep[i]         = 1'b1;
            src_on[i]      = 1'b1;
        end
        drive_srcs();
        n = 0; cleared = 1'b0;
        while (pkt_ports.size() < 7 && n < 80) begin
            step();
            n++;
            if (!cleared && pkt_ports.size() == 3 && obs_fire && obs_grant == 3'd0) begin
                cfg_port_en = 4'b1100;
                cleared     = 1'b1;
            end
        end
        srcs_off();
        cfg_port_en = 4'b1111;
        checks++;
        if (pkt_ports.size() != 7 || log_data.size() != 14) begin
            failures++; $display("FAIL cfg_timeout got=%0d packets %0d beats exp 7 14", pkt_ports.size(), log_data.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (pkt_ports[k] != exp_order[k])
                begin failures++; $display("FAIL cfg_order%0d got=%0d exp=%0d", k, pkt_ports[k], exp_order[k]); end
            end
            for (int k = 0; k < 14; k++) begin
                checks++;
                if (log_port[k] != exp_order[k/2] || log_data[k] !== 8'(exp_order[k/2] * 16 + k % 2) || log_last[k] !== 1'(k % 2))
                begin failures++; $display("FAIL cfg_beat%0d got port=%0d d=%h l=%0b exp port=%0d d=%h",
                    k, log_port[k], log_data[k], log_last[k], exp_order[k/2], 8'(exp_order[k/2] * 16 + k % 2)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d [5];
        int n;
        exp_d = '{8'hD0, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
        pkt_len[2] = 4;
        for (int b = 0; b < 4; b++) pkt_data[2][b] = 8'hC0 + 8'(b);
        src_on[2] = 1'b1;
        drive_srcs();
        step();
        step();
        step();
        #2;
        checks++;
        if (m_tvalid !== 1'b1 || grant_id !== 3'd2)
        begin failures++; $display("FAIL mid_pre got mv=%0b grant=%0d exp 1 2", m_tvalid, grant_id); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0000 || grant_id !== 3'd0)
        begin failures++; $display("FAIL mid_async got mv=%0b busy=%0b str=%b grant=%0d exp 0 0 0000 0",
            m_tvalid, busy, s_tready, grant_id); end
        log_clear();
        beat_idx[2]    = 0;
        pkt_len[0]     = 1;
        pkt_data[0][0] = 8'hD0;
        src_on[0]      = 1'b1;
        drive_srcs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();
        checks++;
        if (obs_busy !== 1'b1 || obs_grant !== 3'd0 || obs_md !== 8'hD0)
        begin failures++; $display("FAIL mid_regrant got busy=%0b grant=%0d d=%h exp 1 0 d0", obs_busy, obs_grant, obs_md); end
        n = 0;
        while (src_on[2] && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (log_data.size() != 5) begin
            failures++; $display("FAIL mid_beats got=%0d exp=5", log_data.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (log_data[k] !== exp_d[k])
                begin failures++; $display("FAIL mid_beat%0d got=%h exp=%h", k, log_data[k], exp_d[k]); end
            end
        end
        srcs_off();
    endtask

    initial begin
        test_reset();
        test_single();
        test_cpl();
        test_rr();
        test_backpressure();
        test_cfg_en();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/taxi_eth_mac_tx_arb.md
# taxi_eth_mac_tx_arb

Packet-granular round-robin arbiter that shares one 8-bit 1G MAC transmit stream among N requesters. It sits between the host-side TX sources and the MAC `s_axis_tx` port. It tags each forwarded packet with its source index and routes MAC TX completions back to the originating source by that tag.

## Interface
Parameters:
- `PORTS`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(PORTS)`: source-tag width.
- `USER_W`, 1: tuser width, passed through unchanged.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronised externally.
- `cfg_port_en` in PORTS: per-port grant enable.
- `s_tdata` in PORTS×8: requester data.
- `s_tvalid` in PORTS: requester valid.
- `s_tready` out PORTS: requester ready.
- `s_tlast` in PORTS: requester end of packet.
- `s_tuser` in PORTS×USER_W: requester user bits.
- `m_tdata` out 8: data to MAC.
- `m_tvalid` out 1: valid to MAC.
- `m_tready` in 1: ready from MAC.
- `m_tlast` out 1: end of packet to MAC.
- `m_tuser` out USER_W: user bits to MAC.
- `m_tid` out ID_W: source tag to MAC.
- `s_cpl_valid` in 1: MAC completion valid.
- `s_cpl_ready` out 1: completion ready to MAC.
- `s_cpl_tid` in ID_W: completion tag from MAC.
- `s_cpl_ts` in 96: completion timestamp from MAC.
- `m_cpl_valid` out PORTS: completion valid to requesters.
- `m_cpl_ready` in PORTS: completion ready from requesters.
- `m_cpl_ts` out 96: completion timestamp, shared by all requesters.
- `busy` out 1: high in PASS.
- `grant_id` out ID_W: currently granted port.

## Operation
- Two-state FSM, IDLE and PASS.
- **IDLE**
  - Request vector is `s_tvalid & cfg_port_en`.
  - If the vector is nonzero, register the grant to the first set bit searching upward, with wrap, from `last_grant+1`.
  - On that edge, load `grant_id` and `last_grant`, then go to PASS.
  - While in IDLE, `s_tready` = 0 and `m_tvalid` = 0.
- **PASS**
  - Combinational forward of the granted port only:
    - `m_tvalid` = `s_tvalid[g]`, and likewise `m_tdata`, `m_tlast`, `m_tuser`.
    - `s_tready[g]` = `m_tready`; every other `s_tready` = 0.
    - `m_tid` = g.
  - A beat with `m_tvalid & m_tready & m_tlast` returns the FSM to IDLE on the next edge.
- Grant is locked for the whole packet:
  - Clearing `cfg_port_en[g]` mid-packet does not abort the packet.
  - The port is skipped only at later arbitrations.
- Completion demux:
  - `m_cpl_valid[i]` = `s_cpl_valid && s_cpl_tid==i`.
  - `s_cpl_ready` = `m_cpl_ready[s_cpl_tid]`.
  - A tag ≥ PORTS is accepted and dropped, with `s_cpl_ready` = 1.
  - `m_cpl_ts` is the same value on all ports.

## Timing
- Reset values:
  - FSM = IDLE.
  - `last_grant` = PORTS-1, so port 0 wins the first arbitration.
  - `grant_id` = 0, `busy` = 0.
  - `m_tvalid` = 0 and `s_tready` = 0, since both are derived from the FSM.
- Arbitration latency: request seen in IDLE at cycle t → grant registered at t+1 → first beat may transfer at t+1.
- One mandatory IDLE bubble after each tlast beat, so back-to-back packets are spaced by ≥1 cycle.
- The forward path has no registers: zero added beat latency.
- Completion demux is fully combinational.
- `rst_n` asserted mid-packet: FSM returns to IDLE immediately and the partial packet is truncated. Upstream reset of the MAC is required.
- Simultaneous requests rotate fairly; each port waits at most PORTS-1 packets.
- A port whose valid drops in IDLE before the grant edge loses the request; no state is retained.

## Configuration
- `TAXI_ETH_TX_ARB_CPL_EN` defined: the completion demux, `m_tid`, and `s_cpl_*`/`m_cpl_*` ports are live.
- Not defined:
  - `m_tid` is tied to 0.
  - `s_cpl_ready` is tied to 1.
  - `m_cpl_valid` is tied to 0.
  - The demux logic is absent; ports remain for a stable footprint.

## Structure
- Package `taxi_eth_tx_arb_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_PASS`);
  - the `TS_W` = 96 constant.
- Sub-module `taxi_arb_rr_sel`:
  - combinational rotating priority select;
  - inputs: request vector and `last_grant`;
  - outputs: `found` and `index`.
- The top level holds the FSM, mux and demux.

## Test plan
- Reset, then port 2 sends a 3-beat packet (0x11, 0x22, 0x33) → grant at the next edge, 3 beats forwarded with `m_tid` = 2, tlast on 0x33, `busy` low one cycle later.
- All 4 ports request continuously, 2-beat packets each → grant order 0, 1, 2, 3, 0, with exactly one idle cycle between packets.
- `m_tready` toggling 1010 during a packet → no beat lost or duplicated, and `s_tready` of non-granted ports stays 0.
- `cfg_port_en` = 4'b1101 with all ports requesting → port 1 never granted; clearing bit 0 mid-packet on port 0 → that packet completes intact.
- Completions with tag 3 while `m_cpl_ready[3]` = 0 → stall; tag 7 (PORTS = 4) → accepted and dropped; `m_cpl_ts` matches the input.
- `rst_n` pulsed low mid-packet → `m_tvalid` goes to 0 asynchronously, and the next arbitration after reset grants port 0.
